// File: rtl/param_sequence_detector.sv
// Serial pattern detector with a runtime-loadable pattern, selectable overlap mode
// and a saturating match counter. dout is a Mealy flag asserted on the matching bit.
module param_sequence_detector #(
  parameter int                 PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] RST_PATTERN = 4'b1101,
  parameter int                 CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               overlap,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count
);

  localparam int                FILL_W    = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] r_pat;
  logic [PAT_LEN-2:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [CNT_W-1:0]   r_count;

  logic [PAT_LEN-1:0] w_window;
  logic               w_full;
  logic               w_accept;
  logic               w_match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
    return (f == FILL_FULL) ? f : f + FILL_W'(1);
  endfunction

  // Match decision: the newest bit completes the window against the stored pattern
  assign w_window = {r_hist, din};
  assign w_full   = (r_fill == FILL_FULL);
  assign w_accept = din_valid & ~cfg_load;
  assign w_match  = w_accept & reset & w_full & (w_window == r_pat);

  assign dout        = w_match;
  assign match_count = r_count;

  // State update: reset beats cfg_load, which beats data acceptance
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pat   <= RST_PATTERN;
      r_hist  <= '0;
      r_fill  <= '0;
      r_count <= '0;
    end else if (cfg_load) begin
      r_pat   <= cfg_pattern;
      r_fill  <= '0;
      r_count <= '0;
    end else if (din_valid) begin
      r_hist <= w_window[PAT_LEN-2:0];
      if (w_match) begin
        r_count <= sat_inc(r_count);
        // Non-overlapping mode forgets every bit of the matched pattern
        r_fill  <= overlap ? FILL_FULL : '0;
      end else begin
        r_fill <= fill_inc(r_fill);
      end
    end
  end

endmodule

// File: tb/tb_param_sequence_detector.sv
// Scoreboard bench: directed steps push expected dout/match_count, a negedge
// monitor pops and compares against the default DUT and a CNT_W=2 instance.
module tb_param_sequence_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic       din_valid;
  logic       overlap;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic       dout;
  logic [7:0] match_count;
  logic       dout2;
  logic [1:0] match_count2;

  int n_cmp = 0;
  int n_bad = 0;
  logic ovl = 1'b1;

  typedef struct {
    logic       d;
    int         c;
    logic       k2;
    logic       d2;
    int         c2;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  param_sequence_detector #(.PAT_LEN(4), .RST_PATTERN(4'b1101), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .dout(dout), .match_count(match_count)
  );

  param_sequence_detector #(.PAT_LEN(4), .RST_PATTERN(4'b1111), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .dout(dout2), .match_count(match_count2)
  );

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (dout !== e.d) begin
        n_bad++;
        $display("FAIL dout @%0t: got %0b expected %0b", $time, dout, e.d);
      end
      n_cmp++;
      if (match_count !== 8'(e.c)) begin
        n_bad++;
        $display("FAIL match_count @%0t: got %0d expected %0d", $time, match_count, e.c);
      end
      if (e.k2) begin
        n_cmp++;
        if (dout2 !== e.d2) begin
          n_bad++;
          $display("FAIL dout_cnt2 @%0t: got %0b expected %0b", $time, dout2, e.d2);
        end
        n_cmp++;
        if (match_count2 !== 2'(e.c2)) begin
          n_bad++;
          $display("FAIL match_count_cnt2 @%0t: got %0d expected %0d", $time, match_count2, e.c2);
        end
      end
    end
  end

  task automatic step(input logic b, input logic v, input logic cl, input logic [3:0] p,
                      input logic r, input logic ed, input int ec,
                      input logic k2 = 1'b0, input logic ed2 = 1'b0, input int ec2 = 0);
    exp_t e;
    @(posedge clk);
    #1;
    din = b; din_valid = v; overlap = ovl; cfg_load = cl; cfg_pattern = p; reset = r;
    e.d = ed; e.c = ec; e.k2 = k2; e.d2 = ed2; e.c2 = ec2;
    q.push_back(e);
  endtask

  task automatic acc(input logic b, input logic ed, input int ec);
    step(b, 1'b1, 1'b0, 4'b0000, 1'b1, ed, ec);
  endtask

  task automatic gap(input logic b, input int ec);
    step(b, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, ec);
  endtask

  task automatic load(input logic [3:0] p, input int ec);
    step(1'b0, 1'b0, 1'b1, p, 1'b1, 1'b0, ec);
  endtask

  initial begin
    reset = 1'b0; din = 1'b0; din_valid = 1'b0; overlap = 1'b1;
    cfg_load = 1'b0; cfg_pattern = 4'b0000;
    @(posedge clk);
    #1;
    // Reset state, both instances
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0);

    // Overlapping 1,1,0,1,1,0,1 with a matching-looking gap after bit 3
    ovl = 1'b1;
    acc(1, 0, 0); acc(1, 0, 0); acc(0, 0, 0);
    gap(1, 0);
    acc(1, 1, 0); acc(1, 0, 1); acc(0, 0, 1); acc(1, 1, 1);
    gap(0, 2);

    // Non-overlapping on the same stream
    ovl = 1'b0;
    load(4'b1101, 2);
    acc(1, 0, 0); acc(1, 0, 0); acc(0, 0, 0); acc(1, 1, 0);
    acc(1, 0, 1); acc(0, 0, 1); acc(1, 0, 1);
    gap(0, 1);

    // Three-cycle valid gap between bits 2 and 3
    ovl = 1'b1;
    load(4'b1101, 1);
    acc(1, 0, 0); acc(1, 0, 0);
    gap(1, 0); gap(0, 0); gap(1, 0);
    acc(0, 0, 0); acc(1, 1, 0);
    gap(0, 1);

    // cfg_load discards earlier bits and ignores a valid din on its cycle
    load(4'b1101, 1);
    acc(1, 0, 0); acc(1, 0, 0);
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 0);
    acc(0, 0, 0); acc(1, 0, 0); acc(1, 0, 0); acc(0, 1, 0);
    gap(0, 1);

    // Mid-pattern reset beats cfg_load and restores the reset pattern
    load(4'b0110, 1);
    load(4'b1101, 0);
    acc(1, 0, 0); acc(1, 0, 0); acc(0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 0);
    acc(1, 0, 0); acc(1, 0, 0); acc(0, 0, 0); acc(1, 1, 0);
    gap(0, 1);

    // All-ones pattern, overlap, saturation at CNT_W=2, then overlap switched off
    ovl = 1'b1;
    load(4'b1111, 1);
    step(1, 1, 0, 4'b0, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 4'b0, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 4'b0, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 4'b0, 1, 1, 0, 1, 1, 0);
    step(1, 1, 0, 4'b0, 1, 1, 1, 1, 1, 1);
    step(1, 1, 0, 4'b0, 1, 1, 2, 1, 1, 2);
    step(0, 0, 0, 4'b0, 1, 0, 3, 1, 0, 3);
    step(1, 1, 0, 4'b0, 1, 1, 3, 1, 1, 3);
    step(0, 0, 0, 4'b0, 1, 0, 4, 1, 0, 3);
    ovl = 1'b0;
    step(1, 1, 0, 4'b0, 1, 1, 4, 1, 1, 3);
    step(1, 1, 0, 4'b0, 1, 0, 5, 1, 0, 3);
    step(0, 0, 0, 4'b0, 1, 0, 5, 1, 0, 3);

    @(posedge clk);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
